// File: rtl/slv_imp_pkg.sv
// Shared definitions for the image-buffer AXI-Lite responder: response codes,
// read FSM states and the address window check.
package slv_imp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DATA,
    RESP
  } rd_state_e;

  // Arguments are widened to 64 bits so the window end cannot wrap for any address width.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/slv_imp_mem_if.sv
// AXI-Lite bus bundle between the image-block master and the buffer responder.
interface slv_imp_mem_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);

  logic                        slv_axi_awvalid;
  logic                        slv_axi_awready;
  logic [AXI_ADDR_WIDTH-1:0]   slv_axi_awaddr;
  logic [2:0]                  slv_axi_awprot;
  logic                        slv_axi_wvalid;
  logic                        slv_axi_wready;
  logic [AXI_DATA_WIDTH-1:0]   slv_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] slv_axi_wstrb;
  logic                        slv_axi_bvalid;
  logic                        slv_axi_bready;
  logic [1:0]                  slv_axi_bresp;
  logic                        slv_axi_arvalid;
  logic                        slv_axi_arready;
  logic [AXI_ADDR_WIDTH-1:0]   slv_axi_araddr;
  logic [2:0]                  slv_axi_arprot;
  logic                        slv_axi_rvalid;
  logic                        slv_axi_rready;
  logic [AXI_DATA_WIDTH-1:0]   slv_axi_rdata;
  logic [1:0]                  slv_axi_rresp;

  modport master (
    output slv_axi_awvalid, slv_axi_awaddr, slv_axi_awprot,
    output slv_axi_wvalid, slv_axi_wdata, slv_axi_wstrb,
    output slv_axi_bready,
    output slv_axi_arvalid, slv_axi_araddr, slv_axi_arprot,
    output slv_axi_rready,
    input  slv_axi_awready, slv_axi_wready, slv_axi_bvalid, slv_axi_bresp,
    input  slv_axi_arready, slv_axi_rvalid, slv_axi_rdata, slv_axi_rresp
  );

  modport slave (
    input  slv_axi_awvalid, slv_axi_awaddr, slv_axi_awprot,
    input  slv_axi_wvalid, slv_axi_wdata, slv_axi_wstrb,
    input  slv_axi_bready,
    input  slv_axi_arvalid, slv_axi_araddr, slv_axi_arprot,
    input  slv_axi_rready,
    output slv_axi_awready, slv_axi_wready, slv_axi_bvalid, slv_axi_bresp,
    output slv_axi_arready, slv_axi_rvalid, slv_axi_rdata, slv_axi_rresp
  );

endinterface

// File: rtl/slv_imp_sram.sv
// Single-port word buffer with per-byte write enables and a one-cycle registered read.
module slv_imp_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [DATA_WIDTH/8-1:0]    we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);

  // One narrow array per byte lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) begin
          mem_q[addr] <= wdata[gi*8 +: 8];
        end
        rdata_q <= mem_q[addr];
      end
    end

    assign rdata[gi*8 +: 8] = rdata_q;
  end

endmodule

// File: rtl/slv_imp_mem.sv
// AXI-Lite responder backed by an on-chip word buffer: AW/W hold registers,
// B response logic, a four-state read FSM and the shared SRAM port mux.
module slv_imp_mem
  import slv_imp_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0010_0000
) (
  input  logic         clk,
  input  logic         PoR_rst,
  slv_imp_mem_if.slave slv,
  output logic         err_sticky
);

  localparam int          BYTES      = AXI_DATA_WIDTH / 8;
  localparam int          BYTE_SHIFT = $clog2(BYTES);
  localparam int          IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [63:0] SPAN       = 64'(MEM_DEPTH) * 64'(BYTES);

  logic                      aw_held_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic                      w_held_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]          w_strb_q;
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                rresp_q;
  logic                      err_q;
  rd_state_e                 rd_state_q, rd_state_d;

  logic                      commit, aw_in_range, ar_in_range, wr_en;
  logic                      ar_ready, r_valid, rd_issue;
  logic [AXI_ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                      sram_en;
  logic [BYTES-1:0]          sram_we;
  logic [IDX_W-1:0]          sram_addr;
  logic [AXI_DATA_WIDTH-1:0] sram_rdata;
  logic                      unused_bits;

  assign commit      = aw_held_q && w_held_q && !bvalid_q;
  assign aw_in_range = addr_in_range(64'(aw_addr_q), 64'(BASE_ADDR), SPAN);
  assign ar_in_range = addr_in_range(64'(ar_addr_q), 64'(BASE_ADDR), SPAN);
  assign wr_en       = commit && aw_in_range;
  assign aw_off      = aw_addr_q - BASE_ADDR;
  assign ar_off      = ar_addr_q - BASE_ADDR;

  // Write commit owns the single SRAM port; the read FSM waits in LOOKUP when they collide.
  assign sram_en   = wr_en || rd_issue;
  assign sram_we   = wr_en ? w_strb_q : '0;
  assign sram_addr = wr_en ? aw_off[BYTE_SHIFT +: IDX_W] : ar_off[BYTE_SHIFT +: IDX_W];

  slv_imp_sram #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (w_data_q),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (PoR_rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (slv.slv_axi_awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= slv.slv_axi_awaddr;
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end
      if (slv.slv_axi_wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        w_data_q <= slv.slv_axi_wdata;
        w_strb_q <= slv.slv_axi_wstrb;
      end else if (commit) begin
        w_held_q <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && slv.slv_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (PoR_rst) begin
      rd_state_q <= IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      IDLE:    if (slv.slv_axi_arvalid) rd_state_d = LOOKUP;
      LOOKUP:  if (!(ar_in_range && wr_en)) rd_state_d = DATA;
      DATA:    rd_state_d = RESP;
      RESP:    if (slv.slv_axi_rready) rd_state_d = IDLE;
      default: rd_state_d = IDLE;
    endcase
  end

  always_comb begin
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    rd_issue = 1'b0;
    case (rd_state_q)
      IDLE:    ar_ready = !PoR_rst;
      LOOKUP:  rd_issue = ar_in_range && !wr_en;
      RESP:    r_valid  = 1'b1;
      default: ;
    endcase
  end

  // Response data is frozen on leaving DATA so it stays stable for the whole RESP phase.
  always_ff @(posedge clk) begin
    if (PoR_rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      if (rd_state_q == IDLE && slv.slv_axi_arvalid) begin
        ar_addr_q <= slv.slv_axi_araddr;
      end
      if (rd_state_q == DATA) begin
        rdata_q <= ar_in_range ? sram_rdata : '0;
        rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if ((commit && !aw_in_range) || (rd_state_q == DATA && !ar_in_range)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign slv.slv_axi_awready = !aw_held_q && !PoR_rst;
  assign slv.slv_axi_wready  = !w_held_q && !PoR_rst;
  assign slv.slv_axi_bvalid  = bvalid_q;
  assign slv.slv_axi_bresp   = bresp_q;
  assign slv.slv_axi_arready = ar_ready;
  assign slv.slv_axi_rvalid  = r_valid;
  assign slv.slv_axi_rdata   = rdata_q;
  assign slv.slv_axi_rresp   = rresp_q;
  assign err_sticky          = err_q;

  assign unused_bits = ^{slv.slv_axi_awprot, slv.slv_axi_arprot, aw_off, ar_off};

endmodule

// File: tb/tb_slv_imp_mem.sv
// Directed bench for the AXI-Lite image-buffer responder.
module tb_slv_imp_mem;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk;
  logic PoR_rst;
  logic err_sticky;
  int   vectors = 0;
  int   miscompares = 0;

  slv_imp_mem_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

  slv_imp_mem #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .MEM_DEPTH      (1024),
    .BASE_ADDR      (32'h0010_0000)
  ) dut (
    .clk        (clk),
    .PoR_rst    (PoR_rst),
    .slv        (bus),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_hs, w_hs;
    int n = 0;
    bus.slv_axi_awaddr = addr; bus.slv_axi_wdata = data; bus.slv_axi_wstrb = strb;
    bus.slv_axi_awvalid = 1'b1; bus.slv_axi_wvalid = 1'b1;
    while ((bus.slv_axi_awvalid || bus.slv_axi_wvalid) && n < 20) begin
      aw_hs = bus.slv_axi_awvalid && bus.slv_axi_awready;
      w_hs  = bus.slv_axi_wvalid && bus.slv_axi_wready;
      tick();
      if (aw_hs) bus.slv_axi_awvalid = 1'b0;
      if (w_hs)  bus.slv_axi_wvalid = 1'b0;
      n++;
    end
    if (bus.slv_axi_awvalid || bus.slv_axi_wvalid) begin
      vectors++; miscompares++;
      $display("FAIL aw_w_accept_timeout: got not accepted expected accepted addr=%h", addr);
      bus.slv_axi_awvalid = 1'b0; bus.slv_axi_wvalid = 1'b0;
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (!bus.slv_axi_bvalid && n < 20) begin tick(); n++; end
    if (!bus.slv_axi_bvalid) begin
      vectors++; miscompares++;
      $display("FAIL bvalid_timeout: got bvalid=0 expected bvalid=1");
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    send_pair(addr, data, strb);
    wait_b();
    resp = bus.slv_axi_bresp;
    bus.slv_axi_bready = 1'b1; tick(); bus.slv_axi_bready = 1'b0;
    $display("WR addr=%h data=%h strb=%h bresp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic hs;
    int n = 0;
    bus.slv_axi_araddr = addr; bus.slv_axi_arvalid = 1'b1;
    while (bus.slv_axi_arvalid && n < 20) begin
      hs = bus.slv_axi_arready;
      tick();
      if (hs) bus.slv_axi_arvalid = 1'b0;
      n++;
    end
    bus.slv_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.slv_axi_rvalid && n < 20) begin tick(); n++; end
    if (!bus.slv_axi_rvalid) begin
      vectors++; miscompares++;
      $display("FAIL rvalid_timeout: got rvalid=0 expected rvalid=1 addr=%h", addr);
    end
    data = bus.slv_axi_rdata; resp = bus.slv_axi_rresp;
    bus.slv_axi_rready = 1'b1; tick(); bus.slv_axi_rready = 1'b0;
    $display("RD addr=%h rdata=%h rresp=%b", addr, data, resp);
  endtask

  task automatic test_reset();
    PoR_rst = 1'b1;
    tick(); tick(); tick();
    vectors++; if (bus.slv_axi_awready !== 1'b0) begin miscompares++; $display("FAIL rst_awready: got %b expected 0", bus.slv_axi_awready); end
    vectors++; if (bus.slv_axi_wready !== 1'b0) begin miscompares++; $display("FAIL rst_wready: got %b expected 0", bus.slv_axi_wready); end
    vectors++; if (bus.slv_axi_arready !== 1'b0) begin miscompares++; $display("FAIL rst_arready: got %b expected 0", bus.slv_axi_arready); end
    vectors++; if (bus.slv_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL rst_bvalid: got %b expected 0", bus.slv_axi_bvalid); end
    vectors++; if (bus.slv_axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b expected 0", bus.slv_axi_rvalid); end
    vectors++; if (bus.slv_axi_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h expected 0", bus.slv_axi_rdata); end
    vectors++; if ({bus.slv_axi_bresp, bus.slv_axi_rresp} !== 4'b0000) begin miscompares++; $display("FAIL rst_resp: got %b expected 0000", {bus.slv_axi_bresp, bus.slv_axi_rresp}); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err_sticky); end
    PoR_rst = 1'b0;
    tick();
    vectors++; if ({bus.slv_axi_awready, bus.slv_axi_wready, bus.slv_axi_arready} !== 3'b111) begin miscompares++; $display("FAIL rel_readys: got %b expected 111", {bus.slv_axi_awready, bus.slv_axi_wready, bus.slv_axi_arready}); end
  endtask

  task automatic test_write_same_cycle();
    bus.slv_axi_awaddr = 32'h0010_0004; bus.slv_axi_wdata = 32'hDEAD_BEEF; bus.slv_axi_wstrb = 4'hF;
    bus.slv_axi_awvalid = 1'b1; bus.slv_axi_wvalid = 1'b1;
    tick();
    bus.slv_axi_awvalid = 1'b0; bus.slv_axi_wvalid = 1'b0;
    vectors++; if (bus.slv_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL t1_bvalid_early: got %b expected 0", bus.slv_axi_bvalid); end
    vectors++; if (bus.slv_axi_awready !== 1'b0) begin miscompares++; $display("FAIL t1_awready_held: got %b expected 0", bus.slv_axi_awready); end
    tick();
    vectors++; if (bus.slv_axi_bvalid !== 1'b1) begin miscompares++; $display("FAIL t1_bvalid: got %b expected 1", bus.slv_axi_bvalid); end
    vectors++; if (bus.slv_axi_bresp !== OKAY) begin miscompares++; $display("FAIL t1_bresp: got %b expected 00", bus.slv_axi_bresp); end
    bus.slv_axi_bready = 1'b1; tick(); bus.slv_axi_bready = 1'b0;
    $display("WR addr=00100004 data=deadbeef strb=f (same-cycle AW/W)");
    // read with exact latency: rvalid on the third sample after the AR handshake
    bus.slv_axi_araddr = 32'h0010_0004; bus.slv_axi_arvalid = 1'b1;
    tick();
    bus.slv_axi_arvalid = 1'b0;
    vectors++; if (bus.slv_axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL t1_rvalid_s1: got %b expected 0", bus.slv_axi_rvalid); end
    tick();
    vectors++; if (bus.slv_axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL t1_rvalid_s2: got %b expected 0", bus.slv_axi_rvalid); end
    tick();
    vectors++; if (bus.slv_axi_rvalid !== 1'b1) begin miscompares++; $display("FAIL t1_rvalid_s3: got %b expected 1", bus.slv_axi_rvalid); end
    vectors++; if (bus.slv_axi_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL t1_rdata: got %h expected deadbeef", bus.slv_axi_rdata); end
    vectors++; if (bus.slv_axi_rresp !== OKAY) begin miscompares++; $display("FAIL t1_rresp: got %b expected 00", bus.slv_axi_rresp); end
    bus.slv_axi_rready = 1'b1; tick(); bus.slv_axi_rready = 1'b0;
    $display("RD addr=00100004 rdata=deadbeef (latency check)");
    vectors++; if ({bus.slv_axi_arready, bus.slv_axi_rvalid} !== 2'b10) begin miscompares++; $display("FAIL t1_back_to_back: got arready,rvalid=%b expected 10", {bus.slv_axi_arready, bus.slv_axi_rvalid}); end
  endtask

  task automatic test_w_first();
    logic [31:0] d;
    logic [1:0]  r;
    bus.slv_axi_wdata = 32'h0000_1234; bus.slv_axi_wstrb = 4'b0011; bus.slv_axi_wvalid = 1'b1;
    tick();
    bus.slv_axi_wvalid = 1'b0;
    vectors++; if (bus.slv_axi_wready !== 1'b0) begin miscompares++; $display("FAIL t2_wready_held: got %b expected 0", bus.slv_axi_wready); end
    tick(); tick();
    vectors++; if (bus.slv_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL t2_bvalid_no_aw: got %b expected 0", bus.slv_axi_bvalid); end
    bus.slv_axi_awaddr = 32'h0010_0004; bus.slv_axi_awvalid = 1'b1;
    tick();
    bus.slv_axi_awvalid = 1'b0;
    wait_b();
    vectors++; if (bus.slv_axi_bresp !== OKAY) begin miscompares++; $display("FAIL t2_bresp: got %b expected 00", bus.slv_axi_bresp); end
    bus.slv_axi_bready = 1'b1; tick(); bus.slv_axi_bready = 1'b0;
    $display("WR addr=00100004 data=00001234 strb=3 (W first)");
    axi_read(32'h0010_0004, d, r);
    vectors++; if (d !== 32'hDEAD_1234) begin miscompares++; $display("FAIL t2_rdata: got %h expected dead1234", d); end
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d;
    logic [1:0]  r;
    send_pair(32'h0010_0008, 32'h1111_1111, 4'hF);
    wait_b();
    send_pair(32'h0010_000C, 32'h2222_2222, 4'hF);
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({bus.slv_axi_bvalid, bus.slv_axi_bresp} !== {1'b1, OKAY}) begin miscompares++; $display("FAIL t3_b_stable[%0d]: got %b expected 100", i, {bus.slv_axi_bvalid, bus.slv_axi_bresp}); end
      vectors++; if ({bus.slv_axi_awready, bus.slv_axi_wready} !== 2'b00) begin miscompares++; $display("FAIL t3_readys_full[%0d]: got %b expected 00", i, {bus.slv_axi_awready, bus.slv_axi_wready}); end
      tick();
    end
    bus.slv_axi_bready = 1'b1; tick(); bus.slv_axi_bready = 1'b0;
    $display("WR addr=00100008 data=11111111 strb=f bresp=00 (held 5 cycles)");
    vectors++; if (bus.slv_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL t3_gap: got %b expected 0", bus.slv_axi_bvalid); end
    tick();
    vectors++; if (bus.slv_axi_bvalid !== 1'b1) begin miscompares++; $display("FAIL t3_second_b: got %b expected 1", bus.slv_axi_bvalid); end
    bus.slv_axi_bready = 1'b1; tick(); bus.slv_axi_bready = 1'b0;
    $display("WR addr=0010000c data=22222222 strb=f bresp=00");
    axi_read(32'h0010_0008, d, r);
    vectors++; if (d !== 32'h1111_1111) begin miscompares++; $display("FAIL t3_rd8: got %h expected 11111111", d); end
    axi_read(32'h0010_000C, d, r);
    vectors++; if (d !== 32'h2222_2222) begin miscompares++; $display("FAIL t3_rdc: got %h expected 22222222", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r;
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL t4_err_before: got %b expected 0", err_sticky); end
    axi_read(32'h0000_0000, d, r);
    vectors++; if (r !== SLVERR) begin miscompares++; $display("FAIL t4_rresp: got %b expected 10", r); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL t4_rdata: got %h expected 0", d); end
    vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL t4_err_after: got %b expected 1", err_sticky); end
    axi_write(32'h0010_0000, 32'hA5A5_A5A5, 4'hF, r);
    axi_write(32'h0020_0000, 32'hFFFF_FFFF, 4'hF, r);
    vectors++; if (r !== SLVERR) begin miscompares++; $display("FAIL t4_bresp: got %b expected 10", r); end
    axi_read(32'h0010_0000, d, r);
    vectors++; if (d !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL t4_mem_unchanged: got %h expected a5a5a5a5", d); end
    axi_write(32'h0010_0FFC, 32'hCAFE_F00D, 4'hF, r);
    vectors++; if (r !== OKAY) begin miscompares++; $display("FAIL t4_last_word_bresp: got %b expected 00", r); end
    axi_read(32'h0010_0FFC, d, r);
    vectors++; if ({r, d} !== {OKAY, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL t4_last_word_rd: got %b/%h expected 00/cafef00d", r, d); end
    axi_read(32'h0010_1000, d, r);
    vectors++; if (r !== SLVERR) begin miscompares++; $display("FAIL t4_past_end: got %b expected 10", r); end
    axi_read(32'h000F_FFFC, d, r);
    vectors++; if (r !== SLVERR) begin miscompares++; $display("FAIL t4_below_base: got %b expected 10", r); end
  endtask

  task automatic test_conflict();
    logic [1:0] r;
    axi_write(32'h0010_0010, 32'h0101_0101, 4'hF, r);
    bus.slv_axi_araddr = 32'h0010_0010; bus.slv_axi_arvalid = 1'b1;
    bus.slv_axi_awaddr = 32'h0010_0010; bus.slv_axi_wdata = 32'h5A5A_5A5A; bus.slv_axi_wstrb = 4'hF;
    bus.slv_axi_awvalid = 1'b1; bus.slv_axi_wvalid = 1'b1;
    tick();
    bus.slv_axi_arvalid = 1'b0; bus.slv_axi_awvalid = 1'b0; bus.slv_axi_wvalid = 1'b0;
    tick();
    vectors++; if ({bus.slv_axi_bvalid, bus.slv_axi_rvalid} !== 2'b10) begin miscompares++; $display("FAIL t5_commit: got bvalid,rvalid=%b expected 10", {bus.slv_axi_bvalid, bus.slv_axi_rvalid}); end
    tick();
    vectors++; if (bus.slv_axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL t5_stall: got rvalid=%b expected 0", bus.slv_axi_rvalid); end
    tick();
    vectors++; if (bus.slv_axi_rvalid !== 1'b1) begin miscompares++; $display("FAIL t5_rvalid: got %b expected 1", bus.slv_axi_rvalid); end
    vectors++; if (bus.slv_axi_rdata !== 32'h5A5A_5A5A) begin miscompares++; $display("FAIL t5_rdata: got %h expected 5a5a5a5a", bus.slv_axi_rdata); end
    bus.slv_axi_rready = 1'b1; bus.slv_axi_bready = 1'b1;
    tick();
    bus.slv_axi_rready = 1'b0; bus.slv_axi_bready = 1'b0;
    $display("RD+WR addr=00100010 wdata=5a5a5a5a (write wins)");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bus.slv_axi_araddr = 32'h0010_0004; bus.slv_axi_arvalid = 1'b1;
    tick();
    bus.slv_axi_arvalid = 1'b0;
    while (!bus.slv_axi_rvalid && n < 20) begin tick(); n++; end
    bus.slv_axi_awaddr = 32'h0020_0000; bus.slv_axi_awvalid = 1'b1;
    tick();
    bus.slv_axi_awvalid = 1'b0;
    vectors++; if ({bus.slv_axi_rvalid, bus.slv_axi_awready} !== 2'b10) begin miscompares++; $display("FAIL t6_setup: got rvalid,awready=%b expected 10", {bus.slv_axi_rvalid, bus.slv_axi_awready}); end
    PoR_rst = 1'b1;
    tick();
    vectors++; if ({bus.slv_axi_rvalid, bus.slv_axi_bvalid, bus.slv_axi_arready} !== 3'b000) begin miscompares++; $display("FAIL t6_in_reset: got rvalid,bvalid,arready=%b expected 000", {bus.slv_axi_rvalid, bus.slv_axi_bvalid, bus.slv_axi_arready}); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL t6_err_cleared: got %b expected 0", err_sticky); end
    PoR_rst = 1'b0;
    #1;
    vectors++; if ({bus.slv_axi_arready, bus.slv_axi_awready, bus.slv_axi_wready} !== 3'b111) begin miscompares++; $display("FAIL t6_released: got arready,awready,wready=%b expected 111", {bus.slv_axi_arready, bus.slv_axi_awready, bus.slv_axi_wready}); end
    bus.slv_axi_wdata = 32'h7777_7777; bus.slv_axi_wstrb = 4'hF; bus.slv_axi_wvalid = 1'b1;
    tick();
    bus.slv_axi_wvalid = 1'b0;
    tick(); tick(); tick();
    vectors++; if (bus.slv_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL t6_aw_hold_empty: got bvalid=%b expected 0", bus.slv_axi_bvalid); end
    bus.slv_axi_awaddr = 32'h0010_0014; bus.slv_axi_awvalid = 1'b1;
    tick();
    bus.slv_axi_awvalid = 1'b0;
    wait_b();
    vectors++; if (bus.slv_axi_bresp !== OKAY) begin miscompares++; $display("FAIL t6_post_bresp: got %b expected 00", bus.slv_axi_bresp); end
    bus.slv_axi_bready = 1'b1; tick(); bus.slv_axi_bready = 1'b0;
    $display("WR addr=00100014 data=77777777 strb=f (after reset)");
  endtask

  initial begin
    PoR_rst = 1'b1;
    bus.slv_axi_awvalid = 1'b0; bus.slv_axi_awaddr = '0; bus.slv_axi_awprot = 3'b000;
    bus.slv_axi_wvalid = 1'b0; bus.slv_axi_wdata = '0; bus.slv_axi_wstrb = '0;
    bus.slv_axi_bready = 1'b0;
    bus.slv_axi_arvalid = 1'b0; bus.slv_axi_araddr = '0; bus.slv_axi_arprot = 3'b000;
    bus.slv_axi_rready = 1'b0;
    test_reset();
    test_write_same_cycle();
    test_w_first();
    test_b_backpressure();
    test_out_of_range();
    test_conflict();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
